// File: rtl/stream_mux_rr.sv
// stream_mux_rr: NUM_CH-to-1 stream multiplexer with fixed-select and
// round-robin arbitration, feeding a single registered output slot with
// valid/ready handshaking. Backpressure is passed upstream; nothing is dropped.
module stream_mux_rr #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // Output slot occupancy; FULL is exactly out_valid=1.
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [SEL_W-1:0] lastGnt_q, lastGnt_d;

  logic             loadEn;
  logic             gntValid;
  logic [SEL_W-1:0] gnt;
  logic             accept;

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_ch    = ch_q;

  // The slot can take a new beat when empty or when its current beat leaves this cycle.
  assign loadEn = !out_valid || out_ready;
  assign accept = loadEn && gntValid && !rst;

  // Pick the granted channel: either the external select or the next requester after the last round-robin winner.
  always_comb begin
    gntValid = 1'b0;
    gnt      = '0;
    if (!mode) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          gntValid = 1'b1;
          gnt      = SEL_W'(i);
        end
      end
    end else begin
      // First pass covers channels above the last winner; the second wraps to the lowest requester.
      for (int i = 0; i < NUM_CH; i++) begin
        if (!gntValid && in_valid[i] && (SEL_W'(i) > lastGnt_q)) begin
          gntValid = 1'b1;
          gnt      = SEL_W'(i);
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (!gntValid && in_valid[i]) begin
          gntValid = 1'b1;
          gnt      = SEL_W'(i);
        end
      end
    end
  end

  // Only the granted channel sees ready, and never while reset is held.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept && gnt == SEL_W'(i)) begin
        in_ready[i] = 1'b1;
      end
    end
  end

  // Next-state of the output slot: load on accept, empty on drain, otherwise hold.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    ch_d      = ch_q;
    lastGnt_d = lastGnt_q;
    if (accept) begin
      state_d = FULL;
      ch_d    = gnt;
      for (int i = 0; i < NUM_CH; i++) begin
        if (gnt == SEL_W'(i)) begin
          data_d = in_data[i*WIDTH +: WIDTH];
        end
      end
      if (mode) begin
        lastGnt_d = gnt;
      end
    end else if (out_valid && out_ready) begin
      state_d = EMPTY;
    end
  end

  // Register the slot and round-robin pointer; reset makes channel 0 the first round-robin pick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      data_q    <= '0;
      ch_q      <= '0;
      lastGnt_q <= SEL_W'(NUM_CH - 1);
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      ch_q      <= ch_d;
      lastGnt_q <= lastGnt_d;
    end
  end

endmodule
